// File: rtl/xrv_if_align_buf_if.sv
// rtl/xrv_if_align_buf_if.sv - fetch-side bus of the halfword-aligning prefetch buffer
interface xrv_if_align_buf_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(2 * DEPTH) + 1;

  logic          jmp;
  logic          jmp_addr_bit1;
  logic [31:0]   wr_data;
  logic          wr_en;
  logic          rd_en;
  logic [31:0]   rd_data;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;

  modport master (
    output jmp, jmp_addr_bit1, wr_data, wr_en, rd_en,
    input  rd_data, full, empty, level
  );

  modport slave (
    input  jmp, jmp_addr_bit1, wr_data, wr_en, rd_en,
    output rd_data, full, empty, level
  );
endinterface

// File: rtl/xrv_if_align_buf.sv
// rtl/xrv_if_align_buf.sv - halfword-granular prefetch buffer presenting an instruction-aligned 32-bit window
module xrv_if_align_buf #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  xrv_if_align_buf_if.slave bus
);
  localparam int N  = 2 * DEPTH;
  localparam int PW = $clog2(N);
  localparam int LW = PW + 1;

  logic [15:0]   hw [N];
  logic [PW-1:0] rp;
  logic [PW-1:0] wp;
  logic [LW-1:0] lvl;
  logic          skip_lo;

  logic [PW-1:0] rp1;
  logic          cur_c;
  logic          empty;
  logic [LW-1:0] need_hw;
  logic [LW-1:0] free_hw;
  logic [LW-1:0] cons_hw;
  logic          wr_ok;
  logic          rd_ok;
  logic [LW-1:0] wr_n;
  logic [LW-1:0] rd_n;

  always_comb begin
    rp1     = rp + PW'(1);
    cur_c   = (hw[rp][1:0] != 2'b11);
    empty   = (lvl == '0) | ((lvl == LW'(1)) & ~cur_c);
    // After a misaligned jump only the upper halfword of the first word is kept
    need_hw = skip_lo ? LW'(1) : LW'(2);
    free_hw = LW'(N) - lvl;
    cons_hw = cur_c ? LW'(1) : LW'(2);
    wr_ok   = bus.wr_en & ~bus.jmp & (free_hw >= need_hw);
    rd_ok   = bus.rd_en & ~bus.jmp & ~empty;
    wr_n    = wr_ok ? need_hw : '0;
    rd_n    = rd_ok ? cons_hw : '0;
  end

  always_comb begin
    bus.rd_data = 32'h0;
    if (lvl >= LW'(2))
      bus.rd_data = {hw[rp1], hw[rp]};
    else if (lvl == LW'(1))
      bus.rd_data = {16'h0, hw[rp]};
    bus.empty = empty;
    bus.full  = (lvl > LW'(N - 4));
    bus.level = lvl;
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      if (skip_lo) begin
        hw[wp] <= bus.wr_data[31:16];
      end else begin
        hw[wp]          <= bus.wr_data[15:0];
        hw[wp + PW'(1)] <= bus.wr_data[31:16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rp      <= '0;
      wp      <= '0;
      lvl     <= '0;
      skip_lo <= 1'b0;
    end else if (bus.jmp) begin
      rp      <= '0;
      wp      <= '0;
      lvl     <= '0;
      skip_lo <= bus.jmp_addr_bit1;
    end else begin
      if (wr_ok) begin
        wp      <= wp + PW'(wr_n);
        skip_lo <= 1'b0;
      end
      if (rd_ok)
        rp <= rp + PW'(rd_n);
      lvl <= lvl + wr_n - rd_n;
    end
  end
endmodule

// File: tb/tb_xrv_if_align_buf.sv
// tb/tb_xrv_if_align_buf.sv - directed and randomized checks of xrv_if_align_buf against a queue model
module tb_xrv_if_align_buf;
  localparam int DEPTH = 4;
  localparam int N     = 2 * DEPTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xrv_if_align_buf_if #(.DEPTH(DEPTH)) bus ();
  xrv_if_align_buf #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [15:0] q[$];
  bit          skip;
  int          passed = 0;
  int          total  = 0;
  int          drops  = 0;

  function automatic bit m_empty();
    return (q.size() == 0) || (q.size() == 1 && q[0][1:0] == 2'b11);
  endfunction

  function automatic logic [31:0] m_rd();
    if (q.size() >= 2) return {q[1], q[0]};
    if (q.size() == 1) return {16'h0, q[0]};
    return 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".level"}, 32'(bus.level), 32'(q.size()));
    check({tag, ".empty"}, 32'(bus.empty), 32'(m_empty()));
    check({tag, ".full"},  32'(bus.full),  32'(q.size() > N - 4));
    check({tag, ".rd_data"}, bus.rd_data, m_rd());
  endtask

  task automatic step(input bit r, input bit j, input bit jb, input bit we,
                      input logic [31:0] wd, input bit re);
    int sz0;
    int need;
    bit emp;
    rst = r; bus.jmp = j; bus.jmp_addr_bit1 = jb;
    bus.wr_en = we; bus.wr_data = wd; bus.rd_en = re;
    @(posedge clk);
    if (r) begin
      q.delete(); skip = 0;
    end else if (j) begin
      q.delete(); skip = jb;
    end else begin
      sz0  = q.size();
      emp  = m_empty();
      need = skip ? 1 : 2;
      if (re && !emp) begin
        if (q[0][1:0] != 2'b11) void'(q.pop_front());
        else begin void'(q.pop_front()); void'(q.pop_front()); end
      end
      if (we) begin
        if (sz0 + need <= N) begin
          if (!skip) q.push_back(wd[15:0]);
          q.push_back(wd[31:16]);
          skip = 0;
        end else drops++;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    bit r, j, jb, we, re;
    logic [31:0] wd;

    step(1, 0, 0, 0, 32'h0, 0);
    step(1, 0, 0, 0, 32'h0, 0);
    check_all("reset");
    check("reset.rd_const", bus.rd_data, 32'h0);
    check("reset.empty_const", 32'(bus.empty), 32'd1);
    for (int i = 0; i < 5; i++) begin
      idle();
      check_all("idle");
    end

    step(0, 0, 0, 1, 32'h0001_0001, 0);
    check_all("cpair.wr");
    check("cpair.wr.rd_const", bus.rd_data, 32'h0001_0001);
    step(0, 0, 0, 0, 32'h0, 1);
    check_all("cpair.rd1");
    check("cpair.rd1.rd_const", bus.rd_data, 32'h0000_0001);
    step(0, 0, 0, 0, 32'h0, 1);
    check_all("cpair.rd2");

    step(0, 0, 0, 1, 32'h0093_0001, 0);
    step(0, 0, 0, 0, 32'h0, 1);
    check_all("straddle.half");
    check("straddle.half.empty_const", 32'(bus.empty), 32'd1);
    step(0, 0, 0, 1, 32'h0000_0000, 0);
    check_all("straddle.whole");
    check("straddle.whole.rd_const", bus.rd_data, 32'h0000_0093);
    step(0, 0, 0, 0, 32'h0, 1);
    check_all("straddle.next");

    step(0, 1, 1, 0, 32'h0, 0);
    check_all("mjmp.flush");
    step(0, 0, 0, 1, 32'h0001_FFFF, 0);
    check_all("mjmp.wr1");
    check("mjmp.wr1.rd_const", bus.rd_data, 32'h0000_0001);
    step(0, 0, 0, 1, 32'h0000_0013, 0);
    check_all("mjmp.wr2");
    check("mjmp.wr2.level_const", 32'(bus.level), 32'd3);

    step(1, 0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 32'h0000_0013, 0);
      check_all("bp.wr");
    end
    check("bp.level_const", 32'(bus.level), 32'd8);
    step(0, 0, 0, 0, 32'h0, 1);
    check_all("bp.rd1");
    step(0, 0, 0, 0, 32'h0, 1);
    check_all("bp.rd2");
    check("bp.rd2.full_const", 32'(bus.full), 32'd0);

    step(0, 1, 0, 1, 32'hDEAD_BEEF, 1);
    check_all("collide");
    idle();
    check_all("collide.after");
    check("collide.rd_const", bus.rd_data, 32'h0);

    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      j  = ($urandom_range(0, 29) == 0);
      jb = 1'($urandom);
      we = ((q.size() <= N - 4) || ($urandom_range(0, 9) == 0)) && ($urandom_range(0, 3) != 0);
      wd = $urandom;
      re = ($urandom_range(0, 2) != 0);
      step(r, j, jb, we, wd, re);
      check_all("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/xrv_if_align_buf.md
# xrv_if_align_buf

Halfword-granular instruction prefetch buffer between the instruction memory port and the fetch/decompress logic of the xriscv fetch stage. It accepts 32-bit word-aligned fetch data and presents a 32-bit window that always starts on the current instruction boundary, so 16-bit compressed and 32-bit instructions can be read back to back, including 32-bit instructions that straddle two fetch words. It flushes on jump and discards the lower halfword of the first fetched word when the jump target is halfword-aligned.

## Interface
- DEPTH, 4, word capacity (power of 2, ≥4); storage is 2*DEPTH halfword entries.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- jmp  in  1  flush request, one-cycle pulse.
- jmp_addr_bit1  in  1  bit 1 of jump target, sampled when jmp=1.
- wr_data  in  32  fetch word; [15:0] is the lower-address halfword.
- wr_en  in  1  write strobe.
- rd_en  in  1  consume the instruction currently shown on rd_data.
- rd_data  out  32  aligned instruction window {hw[rp+1], hw[rp]}.
- full  out  1  back-pressure to the fetch request logic.
- empty  out  1  no complete instruction available.
- level  out  $clog2(2*DEPTH)+1  valid halfword count.

## Operation
- Storage: halfword array hw[0..2*DEPTH-1]; wp and rp are halfword pointers wrapping modulo 2*DEPTH; level is the valid halfword count, 0..2*DEPTH.
- Compressed test: cur_c = (hw[rp][1:0] != 2'b11).
- empty = (level==0) | (level==1 & ~cur_c).
- rd_data: if level≥2, {hw[rp+1], hw[rp]}; if level==1, {16'h0, hw[rp]}; if level==0, 32'h0. Combinational from registers; no write-to-read bypass.
- full = (level > 2*DEPTH-4). This leaves two word slots of headroom for the one-cycle request-to-write latency upstream.
- Write (wr_en & ~jmp):
  - Normal: store wr_data[15:0] at wp and wr_data[31:16] at wp+1, then wp+=2, level+=2.
  - If skip_lo=1: store only wr_data[31:16] at wp, then wp+=1, level+=1, and clear skip_lo.
  - If free halfwords are fewer than required, drop the whole write. State is unchanged. This is a protocol violation and the bench flags it.
- Read (rd_en & ~empty & ~jmp): rp and level advance by 1 if cur_c, else by 2. rd_en while empty is ignored.
- Simultaneous read and write: level += written - consumed, in the same cycle.
- jmp (highest priority): rp=wp=0, level=0, skip_lo=jmp_addr_bit1. Any wr_en or rd_en in the same cycle is ignored; this drops the stale in-flight fetch word.
- skip_lo holds until the first accepted write after jmp. A second jmp before that write reloads it.
- rst (priority over everything): rp=wp=0, level=0, skip_lo=0. Array contents need not be reset.

## Timing
- Reset values: empty=1, full=0, level=0, rd_data=32'h0.
- Write accepted at edge t: the data is reflected in rd_data, empty, level and full from cycle t+1.
- Read at edge t: the next instruction appears on rd_data in cycle t+1. This gives a sustained throughput of one instruction per cycle while non-empty.
- jmp at edge t: empty=1 and level=0 in t+1. With upstream fetch latency, the first new word is written no earlier than edge t+2 and is visible in t+3.
- Straddling 32-bit instruction: empty stays 1 while only its lower halfword is present. It deasserts the cycle after the next word is written.
- Full deasserts the cycle after the read or reads that bring level to ≤2*DEPTH-4.

## Test plan
- Reset: assert rst 2 cycles -> empty=1, full=0, level=0, rd_data=0; deassert, hold idle 5 cycles -> no change.
- Compressed pair: write 0x00010001 -> next cycle rd_data=0x00010001, level=2. Read -> rd_data=0x00000001, level=1. Read -> empty=1, level=0.
- Straddle: write 0x00930001, read once -> level=1, empty=1 (hw=0x0093 is 32-bit). Write 0x00000000 -> next cycle empty=0, rd_data=0x00000093. Read -> level=1, rd_data=0x00000000 (hw[rp]=0x0000, compressed, not empty).
- Misaligned jump: jmp with jmp_addr_bit1=1, then write 0x0001FFFF -> level=1, rd_data=0x00000001, empty=0. A following write 0x00000013 stores both halves -> level=3.
- Back-pressure (DEPTH=4): write 2 words -> level=4, full=0. Write a 3rd -> level=6, full=1. Write a 4th -> level=8. Write a 5th -> dropped, level=8. Read one 32-bit instruction -> level=6, full=1. Read a second -> level=4, full=0.
- Flush collision: with level=4, assert jmp together with wr_en and rd_en -> next cycle level=0, empty=1, rd_data=0. The stale word never appears on rd_data.
